iomem_narrow_bridge: RTL
========================

IOMEM_NARROW_BRIDGE -- requirements
Module: iomem_narrow_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: external bus width in bits; legal values 4, 8, 16, 32.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 255: consecutive no-ack cycles before abort; 0 disables the timeout.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port iomem_valid  input  1  core request.
REQ-006 The block SHALL have port iomem_ready  output  1  one-cycle completion pulse.
REQ-007 The block SHALL have port iomem_wstrb  input  4  byte strobes; 0 means read.
REQ-008 The block SHALL have port iomem_addr  input  32  address.
REQ-009 The block SHALL have port iomem_wdata  input  32  write data.
REQ-010 The block SHALL have port iomem_rdata  output  32  read data.
REQ-011 The block SHALL have port ext_frame  output  1  high for the whole external transaction.
REQ-012 The block SHALL have port ext_oe  output  1  high when the bridge drives ext_do.
REQ-013 The block SHALL have port ext_do  output  DATA_W  outgoing beat.
REQ-014 The block SHALL have port ext_di  input  DATA_W  incoming beat.
REQ-015 The block SHALL have port ext_ack  input  1  target ack/data-valid.
REQ-016 The block SHALL have port bus_err  output  1  timeout flag, pulsed together with iomem_ready.

Function
REQ-017 The FSM SHALL use states IDLE, CMD, ADDR, WDATA, TURN, WAIT, RDATA, DONE; N = 32/DATA_W beats per word.
REQ-018 In IDLE, iomem_valid=1 SHALL latch addr/wdata/wstrb and enter CMD on the next edge; other inputs are ignored outside IDLE.
REQ-019 CMD SHALL last 1 cycle with ext_do[3:0]=wstrb and the upper bits zero; for DATA_W=4 the whole beat is wstrb.
REQ-020 ADDR SHALL send N beats and WDATA SHALL send N beats, both LSB beat first; WDATA is skipped when wstrb=0.
REQ-021 ext_frame SHALL be 1 in CMD through the last of WAIT/RDATA, and 0 in IDLE and DONE.
REQ-022 ext_oe SHALL be 1 only in CMD, ADDR and WDATA.
REQ-023 A write SHALL go from WDATA to WAIT and stay there until ext_ack=1, then go to DONE.
REQ-024 A read SHALL go from ADDR to TURN (1 cycle, ext_oe=0) and then to RDATA.
REQ-025 RDATA SHALL sample ext_di LSB beat first, on ack cycles only; it goes to DONE after N acked beats.
REQ-026 The timeout counter SHALL count consecutive ext_ack=0 cycles in WAIT/RDATA and clear on every ack.
REQ-027 When the timeout count reaches TIMEOUT_CYC, the FSM SHALL go to DONE with bus_err=1; for a read, iomem_rdata=32'hFFFF_FFFF.
REQ-028 DONE SHALL last 1 cycle with iomem_ready=1, then return to IDLE; iomem_rdata holds its value until the next read completes.
REQ-029 An ext_ack in CMD, ADDR, WDATA or TURN SHALL be ignored.
REQ-030 Dropping iomem_valid mid-transaction SHALL NOT abort it.
REQ-031 Minimum latency from valid to ready SHALL be 2N+3 cycles for a write and N+3+N for a read, when acked with zero wait.

Reset
REQ-032 resetn=0 SHALL immediately force IDLE.
REQ-033 resetn=0 SHALL immediately force iomem_ready, ext_frame, ext_oe, bus_err and ext_do to 0, and set iomem_rdata=0.
REQ-034 resetn=0 SHALL immediately clear the beat and timeout counters.
REQ-035 A reset mid-transaction SHALL abandon it with no ready pulse.

Structure
REQ-036 Package iomem_bridge_pkg SHALL hold the state enum, the beat-count constant function N(DATA_W), and the 32'hFFFF_FFFF error word.
REQ-037 The timeout counter SHALL be sub-module iomem_bridge_timeout, with parameter TIMEOUT_CYC, inputs en and clr, and output expired.
REQ-038 Shift registers and the FSM SHALL stay in the top module.

Verification
REQ-039 Write with DATA_W=8: wstrb=4'hF, addr=32'h0300_0010, wdata=32'hDEADBEEF, ack in the 1st WAIT cycle -> ext_do sequence 0F,10,00,00,03,EF,BE,AD,DE; ready at cycle 11; bus_err=0.
REQ-040 Read with DATA_W=4: addr=32'h0300_0004, with ext_di beats 1..8 acked and 2 wait cycles inserted -> iomem_rdata=32'h87654321; ready exactly 1 cycle.
REQ-041 Read with TIMEOUT_CYC=5 and ext_ack held 0 -> ready with bus_err=1 on the 6th WAIT/RDATA cycle; rdata=32'hFFFF_FFFF.
REQ-042 resetn pulsed low during ADDR beat 2 -> ext_frame and ext_oe go 0 asynchronously; no ready; next request runs normally from CMD.
REQ-043 DATA_W=32 back-to-back write then read -> 1 beat per phase; write latency 5 cycles; valid held during DONE does not start an extra transaction.

Source files
------------

// File: rtl/iomem_bridge_pkg.sv
// Shared types and constants for the iomem narrow bridge.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: FSM state enum, beats-per-word constant function, error read word.
package iomem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    TURN,
    WAIT,
    RDATA,
    DONE
  } state_t;

  // Read data returned when the target never answers.
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  // N: number of external beats needed to move one 32-bit word.
  function automatic int n_beats(input int data_w);
    return 32 / data_w;
  endfunction

endpackage

// File: rtl/iomem_bridge_timeout.sv
// Counts consecutive no-ack cycles and flags when the limit is hit.
// Latency: expired is combinational, asserted during the TIMEOUT_CYC-th counted cycle.
// Backpressure: none; en/clr are driven every cycle by the bridge FSM.
// Ports: clk, resetn (async active-low); en = a waiting cycle without ack;
//        clr = restart the count (ack seen or not waiting); expired = abort now.
module iomem_bridge_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // The count only needs to reach TIMEOUT_CYC-1: expiry is decided in the
  // cycle that would have made it TIMEOUT_CYC.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // TIMEOUT_CYC == 0 disables the abort entirely.
  assign expired = (TIMEOUT_CYC != 0) && en && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (TIMEOUT_CYC != 0) && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/iomem_narrow_bridge.sv
// Bridges a 32-bit iomem request onto a narrow framed external bus (cmd, addr, data beats).
// Latency: write 2N+3 cycles, read 2N+3 cycles valid-to-ready with zero-wait acks.
// Backpressure: target stalls by withholding ext_ack in WAIT/RDATA; optional timeout aborts.
// Ports: iomem_valid/ready/wstrb/addr/wdata/rdata = core side (ready is a 1-cycle pulse);
//        ext_frame/oe/do/di/ack = external bus; bus_err pulses with ready on timeout.
module iomem_narrow_bridge
  import iomem_bridge_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              ext_frame,
  output logic              ext_oe,
  output logic [DATA_W-1:0] ext_do,
  input  logic [DATA_W-1:0] ext_di,
  input  logic              ext_ack,
  output logic              bus_err
);

  localparam int         N         = n_beats(DATA_W);
  localparam logic [3:0] LAST_BEAT = 4'(N - 1);

  state_t      state;
  logic [3:0]  beat_cnt;
  logic [31:0] addr_sh;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_sh;
  logic        is_wr;

  logic        in_wait;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo_expired;
  logic [31:0] rdata_nxt;

  // Acks only matter while waiting for the target; elsewhere they are ignored.
  assign in_wait = (state == WAIT) || (state == RDATA);
  assign tmo_en  = in_wait && !ext_ack;
  assign tmo_clr = !in_wait || ext_ack;

  // Incoming beats enter at the top so the first (LSB) beat ends up at bit 0.
  assign rdata_nxt = 32'({ext_di, rdata_sh} >> DATA_W);

  iomem_bridge_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .en     (tmo_en),
    .clr    (tmo_clr),
    .expired(tmo_expired)
  );

  // Bus outputs are registered: each transition loads the values the
  // destination state must present during its own cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      addr_sh     <= '0;
      wdata_sh    <= '0;
      rdata_sh    <= '0;
      is_wr       <= 1'b0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      bus_err     <= 1'b0;
      ext_frame   <= 1'b0;
      ext_oe      <= 1'b0;
      ext_do      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iomem_valid) begin
            addr_sh   <= iomem_addr;
            wdata_sh  <= iomem_wdata;
            is_wr     <= |iomem_wstrb;
            beat_cnt  <= '0;
            ext_frame <= 1'b1;
            ext_oe    <= 1'b1;
            ext_do    <= DATA_W'(iomem_wstrb);
            state     <= CMD;
          end
        end

        CMD: begin
          ext_do   <= addr_sh[DATA_W-1:0];
          addr_sh  <= addr_sh >> DATA_W;
          beat_cnt <= '0;
          state    <= ADDR;
        end

        ADDR: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            if (is_wr) begin
              ext_do   <= wdata_sh[DATA_W-1:0];
              wdata_sh <= wdata_sh >> DATA_W;
              state    <= WDATA;
            end else begin
              ext_oe <= 1'b0;
              ext_do <= '0;
              state  <= TURN;
            end
          end else begin
            ext_do   <= addr_sh[DATA_W-1:0];
            addr_sh  <= addr_sh >> DATA_W;
            beat_cnt <= beat_cnt + 4'd1;
          end
        end

        WDATA: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            ext_oe   <= 1'b0;
            ext_do   <= '0;
            state    <= WAIT;
          end else begin
            ext_do   <= wdata_sh[DATA_W-1:0];
            wdata_sh <= wdata_sh >> DATA_W;
            beat_cnt <= beat_cnt + 4'd1;
          end
        end

        // One dead cycle so the target can take over the data lines.
        TURN: begin
          beat_cnt <= '0;
          state    <= RDATA;
        end

        WAIT: begin
          if (ext_ack) begin
            ext_frame   <= 1'b0;
            iomem_ready <= 1'b1;
            state       <= DONE;
          end else if (tmo_expired) begin
            ext_frame   <= 1'b0;
            iomem_ready <= 1'b1;
            bus_err     <= 1'b1;
            state       <= DONE;
          end
        end

        RDATA: begin
          if (ext_ack) begin
            rdata_sh <= rdata_nxt;
            if (beat_cnt == LAST_BEAT) begin
              iomem_rdata <= rdata_nxt;
              ext_frame   <= 1'b0;
              iomem_ready <= 1'b1;
              state       <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end else if (tmo_expired) begin
            iomem_rdata <= ERR_WORD;
            ext_frame   <= 1'b0;
            iomem_ready <= 1'b1;
            bus_err     <= 1'b1;
            state       <= DONE;
          end
        end

        // iomem_valid is still high here; it is deliberately not sampled.
        DONE: begin
          iomem_ready <= 1'b0;
          bus_err     <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
